// File: rtl/rotate_pkg.sv
// Shared constants and encodings for the rotate arbiter slice.
package rotate_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic ROT_RIGHT = 1'b0;
    localparam logic ROT_LEFT  = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rotate_arbiter_if.sv
// Two-requester rotate request/response bundle; master = requesters, slave = arbiter.
interface rotate_arbiter_if;
    import rotate_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_dir;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_b1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output req_valid, req_dir, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_dir, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/rotate_core.sv
// Combinational 5-stage logarithmic barrel rotator, direction selectable.
module rotate_core
    import rotate_pkg::*;
(
    input  logic               dir,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  y
);

    always_comb begin
        y = a;
        // Stage i rotates by 2**i when shamt[i] is set.
        for (int unsigned i = 0; i < SHAMT_W; i++) begin
            if (shamt[i[2:0]]) begin
                if (dir == ROT_LEFT)
                    y = (y << (1 << i)) | (y >> (DATA_W - (1 << i)));
                else
                    y = (y >> (1 << i)) | (y << (DATA_W - (1 << i)));
            end
        end
    end

endmodule

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one rotate core between two requesters,
// with a one-entry result buffer returned to the issuing port.
module rotate_arbiter
    import rotate_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    rotate_arbiter_if.slave  bus
);

    state_t              state, state_nx;
    logic                owner, owner_nx;
    logic                prio, prio_nx;
    logic [DATA_W-1:0]   data_q, data_nx;

    logic                can_accept;
    logic                grant;
    logic                accept;
    logic                sel_dir;
    logic [DATA_W-1:0]   sel_a;
    logic [SHAMT_W-1:0]  sel_shamt;
    logic [DATA_W-1:0]   rot_y;

    always_comb begin
        unique case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = prio;
        endcase
    end

    assign sel_dir   = grant ? bus.req_dir[1] : bus.req_dir[0];
    assign sel_a     = grant ? bus.req_a1 : bus.req_a0;
    assign sel_shamt = grant ? bus.req_b1[SHAMT_W-1:0] : bus.req_b0[SHAMT_W-1:0];

    rotate_core u_core (
        .dir   (sel_dir),
        .a     (sel_a),
        .shamt (sel_shamt),
        .y     (rot_y)
    );

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        prio_nx  = prio;
        data_nx  = data_q;

        // A draining buffer can take the next result in the same cycle.
        can_accept = (state == ST_EMPTY) || bus.rsp_ready[owner];
        accept     = clr_n && can_accept && (|bus.req_valid);

        bus.req_ready        = '0;
        bus.req_ready[grant] = clr_n && can_accept;

        if (accept) begin
            state_nx = ST_FULL;
            owner_nx = grant;
            prio_nx  = ~grant;
            data_nx  = rot_y;
        end else if ((state == ST_FULL) && bus.rsp_ready[owner]) begin
            state_nx = ST_EMPTY;
        end

        bus.rsp_valid = '0;
        if (state == ST_FULL)
            bus.rsp_valid[owner] = 1'b1;
        bus.rsp_data = data_q;
        bus.busy     = (state == ST_FULL);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= ST_EMPTY;
            owner  <= 1'b0;
            prio   <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            prio   <= prio_nx;
            data_q <= data_nx;
        end
    end

endmodule
